// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter (instruction fetch and LSU) for a single data-memory port; LSU wins ties,
// owners alternate on back-to-back completion. Optional bus timeout: `define DMEM_TIMEOUT_EN.
module dmem_bus_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW/8-1:0] lsu_mask,
  input  logic [DW-1:0]   lsu_wdata,
  output logic            lsu_gnt,
  output logic            lsu_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_mask,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_valid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            if_stall,
  output logic            lsu_stall,
  output logic            bus_err
);

  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_IF  = 2'd1,
    S_BUSY_LSU = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dmem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t          r_state;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [MW-1:0]   r_mem_mask;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_if_gnt;
  logic            r_lsu_gnt;
  logic            w_busy;
  logic            w_timeout;
  logic            w_done;
  logic            w_grant_if;
  logic            w_grant_lsu;
  logic [DW-1:0]   w_rdata;

  assign w_busy = (r_state != S_IDLE);

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_bus_err;

  assign w_timeout = w_busy && !mem_valid && (r_wait_cnt == CW'(TIMEOUT_CYCLES));
  assign bus_err   = r_bus_err;

  // Wait counter restarts on every grant; the error flag stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= {CW{1'b0}};
      r_bus_err  <= 1'b0;
    end else begin
      if (w_grant_if || w_grant_lsu) begin
        r_wait_cnt <= {CW{1'b0}};
      end else if (w_busy && !mem_valid && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end else begin
        r_bus_err <= r_bus_err;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  assign w_done  = w_busy && (mem_valid || w_timeout);
  assign w_rdata = w_timeout ? DW'(32'hDEAD_BEEF) : mem_rdata;

  // Grant decision: ties go to the LSU, a completing owner hands over to the other side.
  always_comb begin
    w_grant_if  = 1'b0;
    w_grant_lsu = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lsu_req) begin
          w_grant_lsu = 1'b1;
        end else begin
          w_grant_if = if_req;
        end
      end
      S_BUSY_IF:  w_grant_lsu = w_done && lsu_req;
      S_BUSY_LSU: w_grant_if  = w_done && if_req;
      default: begin
        w_grant_if  = 1'b0;
        w_grant_lsu = 1'b0;
      end
    endcase
  end

  // Arbiter FSM; the bus payload is captured only on a grant and held until completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_mask  <= {MW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_if_gnt    <= 1'b0;
      r_lsu_gnt   <= 1'b0;
    end else begin
      r_if_gnt  <= w_grant_if;
      r_lsu_gnt <= w_grant_lsu;
      if (w_grant_lsu) begin
        r_state     <= S_BUSY_LSU;
        r_mem_req   <= 1'b1;
        r_mem_we    <= lsu_we;
        r_mem_addr  <= lsu_addr;
        r_mem_mask  <= lsu_mask;
        r_mem_wdata <= lsu_wdata;
      end else if (w_grant_if) begin
        r_state     <= S_BUSY_IF;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_mask  <= {MW{1'b1}};
      end else if (w_done) begin
        r_state   <= S_IDLE;
        r_mem_req <= 1'b0;
      end else begin
        r_state   <= r_state;
        r_mem_req <= r_mem_req;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_mask  = r_mem_mask;
  assign mem_wdata = r_mem_wdata;
  assign if_gnt    = r_if_gnt;
  assign lsu_gnt   = r_lsu_gnt;

  assign if_valid  = w_done && (r_state == S_BUSY_IF);
  assign lsu_valid = w_done && (r_state == S_BUSY_LSU);
  assign if_rdata  = w_rdata;
  assign lsu_rdata = w_rdata;
  assign if_stall  = if_req && !if_valid;
  assign lsu_stall = lsu_req && !lsu_valid;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: two requester agents, a wait-state memory model,
// an expected-grant queue checked on every grant and a per-transaction response check.
module tb_dmem_bus_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
  } txn_t;

  typedef struct {
    logic        lsu;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } bus_t;

  bit          clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_valid, lsu_stall;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_mask, mem_mask;
  logic        mem_req, mem_we, mem_valid, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   vectors = 0;
  int   miscompares = 0;
  int   mem_wait = 0;
  int   wcnt;
  int   lsu_valid_cnt = 0;
  bit   if_busy = 1'b0;
  bit   lsu_busy = 1'b0;
  txn_t if_q[$];
  txn_t lsu_q[$];
  bus_t bus_q[$];

`ifdef DMEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  dmem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_mask(lsu_mask),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_valid(lsu_valid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_mask(mem_mask),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .lsu_stall(lsu_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Memory model: responds after mem_wait extra cycles, data is a fixed function of address.
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (mem_req && !mem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign mem_valid = mem_req && (wcnt == mem_wait);
  assign mem_rdata = mem_addr ^ 32'h1234_5678;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_if(input logic [31:0] addr, input int stall);
    txn_t t;
    bus_t b;
    t.addr = addr; t.we = 1'b0; t.mask = 4'hF; t.wdata = 32'h0;
    t.rdata = addr ^ 32'h1234_5678; t.stall = stall;
    b.lsu = 1'b0; b.we = 1'b0; b.addr = addr; b.mask = 4'hF; b.wdata = 32'h0;
    if_q.push_back(t);
    bus_q.push_back(b);
  endtask

  task automatic push_lsu(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int stall);
    txn_t t;
    bus_t b;
    t.addr = addr; t.we = we; t.mask = mask; t.wdata = wdata; t.rdata = rdata; t.stall = stall;
    b.lsu = 1'b1; b.we = we; b.addr = addr; b.mask = mask; b.wdata = wdata;
    lsu_q.push_back(t);
    bus_q.push_back(b);
  endtask

  // Waits until both agents are idle; counts cycles where mem_req dropped after first rising.
  task automatic wait_done(output int gaps);
    int  n;
    bit  seen;
    n = 0; seen = 1'b0; gaps = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (!if_busy && !lsu_busy && if_q.size() == 0 && lsu_q.size() == 0) break;
      if (mem_req) seen = 1'b1;
      else if (seen) gaps++;
    end
    check("done_in_budget", 32'(n < 300), 32'd1);
  endtask

  // Fetch agent: raises if_req with the next address, drops it after the response edge.
  initial begin : if_agent
    txn_t t;
    int   stalls;
    bit   done;
    if_req = 1'b0; if_addr = 32'h0; stalls = 0; done = 1'b0;
    t = '{32'h0, 1'b0, 4'h0, 32'h0, 32'h0, -1};
    forever begin
      @(negedge clk);
      if (if_req && if_stall) stalls++;
      if (if_req && if_valid) begin
        check("if_rdata", if_rdata, t.rdata);
        if (t.stall >= 0) check("if_stall_cycles", stalls, t.stall);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        if_req = 1'b0; if_busy = 1'b0; done = 1'b0;
      end else begin
        if (done) begin if_req = 1'b0; if_busy = 1'b0; done = 1'b0; end
        if (!if_busy && if_q.size() > 0) begin
          t = if_q.pop_front();
          if_req = 1'b1; if_addr = t.addr; stalls = 0; if_busy = 1'b1;
        end
      end
    end
  end

  // LSU agent: same handshake as the fetch agent with the full store/load payload.
  initial begin : lsu_agent
    txn_t t;
    int   stalls;
    bit   done;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = 32'h0; lsu_mask = 4'h0; lsu_wdata = 32'h0;
    stalls = 0; done = 1'b0;
    t = '{32'h0, 1'b0, 4'h0, 32'h0, 32'h0, -1};
    forever begin
      @(negedge clk);
      if (lsu_req && lsu_stall) stalls++;
      if (lsu_req && lsu_valid) begin
        if (!t.we) check("lsu_rdata", lsu_rdata, t.rdata);
        if (t.stall >= 0) check("lsu_stall_cycles", stalls, t.stall);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        lsu_req = 1'b0; lsu_busy = 1'b0; done = 1'b0;
      end else begin
        if (done) begin lsu_req = 1'b0; lsu_busy = 1'b0; done = 1'b0; end
        if (!lsu_busy && lsu_q.size() > 0) begin
          t = lsu_q.pop_front();
          lsu_req = 1'b1; lsu_we = t.we; lsu_addr = t.addr; lsu_mask = t.mask;
          lsu_wdata = t.wdata; stalls = 0; lsu_busy = 1'b1;
        end
      end
    end
  end

  // Bus monitor: grants must match the expected order, payload must hold while busy.
  initial begin : bus_mon
    bus_t e;
    bus_t cur;
    cur = '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("one_valid", 32'(if_valid & lsu_valid), 32'd0);
        check("if_valid_unreq", 32'(if_valid & ~if_req), 32'd0);
        check("lsu_valid_unreq", 32'(lsu_valid & ~lsu_req), 32'd0);
        if (lsu_valid) lsu_valid_cnt++;
        if (if_gnt || lsu_gnt) begin
          check("gnt_expected", 32'(bus_q.size() != 0), 32'd1);
          if (bus_q.size() != 0) begin
            e = bus_q.pop_front();
            cur = e;
            check("gnt_owner", 32'(lsu_gnt), 32'(e.lsu));
            check("gnt_single", 32'(if_gnt & lsu_gnt), 32'd0);
            check("gnt_mem_req", 32'(mem_req), 32'd1);
            check("gnt_we", 32'(mem_we), 32'(e.we));
            check("gnt_addr", mem_addr, e.addr);
            check("gnt_mask", 32'(mem_mask), 32'(e.mask));
            if (e.we) check("gnt_wdata", mem_wdata, e.wdata);
          end
        end else if (mem_req) begin
          check("hold_addr", mem_addr, cur.addr);
          check("hold_mask", 32'(mem_mask), 32'(cur.mask));
          check("hold_we", 32'(mem_we), 32'(cur.we));
        end
      end
    end
  end

  initial begin : main
    int gaps;
    int n;
    int vcnt0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_mask", 32'(mem_mask), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_gnts", 32'({if_gnt, lsu_gnt}), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch with a zero-wait memory.
    mem_wait = 0;
    push_if(32'h0000_0080, 1);
    wait_done(gaps);
    check("t1_gaps", gaps, 0);

    // Simultaneous store and fetch: LSU first, then IF with no idle cycle in between.
    push_lsu(1'b1, 32'h0000_0100, 4'b0011, 32'hA5A5_1234, 32'h0, 1);
    push_if(32'h0000_0040, 2);
    wait_done(gaps);
    check("t2_gaps", gaps, 0);

    // Continuous traffic from both sides must alternate with mem_req held high.
    mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      push_lsu(1'b0, 32'h0000_0200 + 32'(i * 4), 4'hF, 32'h0,
               (32'h0000_0200 + 32'(i * 4)) ^ 32'h1234_5678, -1);
      push_if(32'h0000_1000 + 32'(i * 4), -1);
    end
    wait_done(gaps);
    check("t3_gaps", gaps, 0);

`ifndef DMEM_TIMEOUT_EN
    // Load with five wait states.
    mem_wait = 5;
    push_lsu(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h1234_5678, 6);
    wait_done(gaps);
    check("t4_gaps", gaps, 0);
`endif

    // Reset in the middle of an LSU wait drops the transaction silently.
    mem_wait = 10;
    push_lsu(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h0, -1);
    n = 0;
    while (!lsu_gnt && n < 20) begin @(negedge clk); n++; end
    check("t5_gnt_seen", 32'(lsu_gnt), 32'd1);
    repeat (3) @(negedge clk);
    vcnt0 = lsu_valid_cnt;
    rst = 1'b1;
    #1;
    check("t5_rst_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_no_valid", lsu_valid_cnt, vcnt0);
    check("t5_mem_req_idle", 32'(mem_req), 32'd0);
    check("t5_lsu_idle", 32'(lsu_busy), 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // Memory never answers: abort after the timeout with a poison value and sticky error.
    mem_wait = 1000;
    push_lsu(1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'hDEAD_BEEF, TO + 1);
    wait_done(gaps);
    check("t6_bus_err", 32'(bus_err), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_bus_err_held", 32'(bus_err), 32'd1);
    check("t6_mem_req_idle", 32'(mem_req), 32'd0);
`endif

    check("bus_q_drained", bus_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
